axis_tlast_framer: RTL and testbench

//  AXI-Stream pass-through framer: slices a continuous sample stream into packets and drives m_axis_tlast.

---
 rtl/axis_tlast_framer_pkg.sv | 24 ++
 rtl/axis_tlast_framer_if.sv | 28 ++
 rtl/axis_tlast_framer_skid_buf.sv | 77 +++++++
 rtl/axis_tlast_framer.sv | 116 +++++++++++
 tb/tb_axis_tlast_framer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_tlast_framer_pkg.sv
// Shared definitions for the AXI-Stream tlast framer.
//   - Default parameter values for the framer and its stream interface.
//   - payload_width(): width of the bundle carried through the skid buffer,
//     i.e. tdata + tlast (+ tuser when TLAST_FRAMER_SOF_EN is defined).
// Build option: TLAST_FRAMER_SOF_EN adds a start-of-frame tuser bit.
package axis_tlast_framer_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_COUNTER_WIDTH = 16;
  localparam int unsigned DEF_NUMBER        = 16;
  localparam int unsigned DEF_PKT_CNT_WIDTH = 32;

`ifdef TLAST_FRAMER_SOF_EN
  localparam int unsigned SOF_BITS = 1;
`else
  localparam int unsigned SOF_BITS = 0;
`endif

  // tdata + tlast + optional start-of-frame flag
  function automatic int unsigned payload_width(input int unsigned data_width);
    return data_width + 1 + SOF_BITS;
  endfunction

endpackage

// File: rtl/axis_tlast_framer_if.sv
// AXI-Stream bundle used on both sides of the framer.
//   tdata  : sample payload (DATA_WIDTH bits)
//   tvalid : beat valid
//   tready : sink ready
//   tlast  : last beat of packet
//   tuser  : start of frame (only with TLAST_FRAMER_SOF_EN)
// Modports: master drives data/valid/last(/user), slave drives ready.
interface axis_tlast_framer_if
  import axis_tlast_framer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
`ifdef TLAST_FRAMER_SOF_EN
  logic                  tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
`else
  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
`endif

endinterface

// File: rtl/axis_tlast_framer_skid_buf.sv
// axis_skid_buf: generic 2-entry AXI-Stream register slice.
//   clk, reset_n           : clock, asynchronous active-low reset
//   in_data/in_valid       : upstream payload and valid
//   in_ready               : registered "skid entry empty"
//   out_data/out_valid     : registered downstream payload and valid
//   out_ready              : downstream ready
// Sustains one beat per clock; the second entry absorbs the beat accepted
// in the cycle where the output stalls, so in_ready can be a register.
module axis_skid_buf #(
  parameter int unsigned C_WIDTH = 33
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [C_WIDTH-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [C_WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [C_WIDTH-1:0] out_data_reg, out_data_next;
  logic [C_WIDTH-1:0] skid_data_reg, skid_data_next;
  logic               out_valid_reg, out_valid_next;
  logic               skid_valid_reg, skid_valid_next;
  logic               ready_reg;
  logic               in_fire;
  logic               out_free;

  assign in_fire  = in_valid && ready_reg;
  assign out_free = !out_valid_reg || out_ready;

  // ready_reg tracks !skid_valid_reg, so a beat is never accepted while the
  // skid entry is occupied.
  always_comb begin
    out_data_next   = out_data_reg;
    out_valid_next  = out_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_valid_next = skid_valid_reg;
    if (out_free) begin
      if (skid_valid_reg) begin
        out_data_next   = skid_data_reg;
        out_valid_next  = 1'b1;
        skid_valid_next = 1'b0;
      end else begin
        out_valid_next = in_fire;
        if (in_fire) begin
          out_data_next = in_data;
        end
      end
    end else if (in_fire) begin
      skid_data_next  = in_data;
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      skid_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b0;
    end else begin
      out_data_reg   <= out_data_next;
      out_valid_reg  <= out_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_valid_reg <= skid_valid_next;
      ready_reg      <= !skid_valid_next;
    end
  end

  assign in_ready  = ready_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: rtl/axis_tlast_framer.sv
// axis_tlast_framer: slices a continuous AXI-Stream into packets.
//   clk, reset_n : clock, asynchronous active-low reset
//   s_axis       : input stream (slave modport); its tlast/tuser are ignored
//   m_axis       : framed output stream (master modport), registered
//   cfg_len      : packet length in beats, 0 selects C_NUMBER; latched on
//                  the first beat of each packet
//   flush        : pulse, ends the current packet on the next accepted beat
//   beat_count   : index of the next beat within the packet
//   pkt_count    : completed packets (counted at input acceptance), wraps
// Build option: TLAST_FRAMER_SOF_EN adds m_axis.tuser on the first beat.
module axis_tlast_framer
  import axis_tlast_framer_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned C_COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int unsigned C_NUMBER        = DEF_NUMBER,
  parameter int unsigned C_PKT_CNT_WIDTH = DEF_PKT_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  axis_tlast_framer_if.slave         s_axis,
  axis_tlast_framer_if.master        m_axis,
  input  logic [C_COUNTER_WIDTH-1:0] cfg_len,
  input  logic                       flush,
  output logic [C_COUNTER_WIDTH-1:0] beat_count,
  output logic [C_PKT_CNT_WIDTH-1:0] pkt_count
);

  localparam int unsigned PAYLOAD_W = payload_width(C_DATA_WIDTH);
  localparam logic [C_COUNTER_WIDTH-1:0] NUMBER_W = C_COUNTER_WIDTH'(C_NUMBER);
  localparam logic [C_COUNTER_WIDTH-1:0] BEAT_ONE = C_COUNTER_WIDTH'(1);
  localparam logic [C_PKT_CNT_WIDTH-1:0] PKT_ONE  = C_PKT_CNT_WIDTH'(1);

  logic [C_COUNTER_WIDTH-1:0] beat_count_reg, beat_count_next;
  logic [C_PKT_CNT_WIDTH-1:0] pkt_count_reg, pkt_count_next;
  logic [C_COUNTER_WIDTH-1:0] len_q_reg, len_q_next;
  logic                       flush_pend_reg, flush_pend_next;

  logic                       s_ready;
  logic                       in_fire;
  logic                       first_beat;
  logic [C_COUNTER_WIDTH-1:0] len_first;
  logic [C_COUNTER_WIDTH-1:0] len_eff;
  logic                       beat_last;
  logic [PAYLOAD_W-1:0]       payload_in;
  logic [PAYLOAD_W-1:0]       payload_out;

  assign in_fire    = s_axis.tvalid && s_ready;
  assign first_beat = (beat_count_reg == '0);
  assign len_first  = (cfg_len == '0) ? NUMBER_W : cfg_len;
  // First beat of a packet sees cfg_len directly; later beats use the latch.
  assign len_eff    = first_beat ? len_first : len_q_reg;
  assign beat_last  = (beat_count_reg == len_eff - BEAT_ONE) || flush || flush_pend_reg;

  always_comb begin
    beat_count_next = beat_count_reg;
    pkt_count_next  = pkt_count_reg;
    len_q_next      = len_q_reg;
    flush_pend_next = flush_pend_reg;
    if (in_fire) begin
      flush_pend_next = 1'b0;
      if (first_beat) begin
        len_q_next = len_first;
      end
      if (beat_last) begin
        beat_count_next = '0;
        pkt_count_next  = pkt_count_reg + PKT_ONE;
      end else begin
        beat_count_next = beat_count_reg + BEAT_ONE;
      end
    end else if (flush) begin
      flush_pend_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_count_reg <= '0;
      pkt_count_reg  <= '0;
      len_q_reg      <= NUMBER_W;
      flush_pend_reg <= 1'b0;
    end else begin
      beat_count_reg <= beat_count_next;
      pkt_count_reg  <= pkt_count_next;
      len_q_reg      <= len_q_next;
      flush_pend_reg <= flush_pend_next;
    end
  end

`ifdef TLAST_FRAMER_SOF_EN
  assign payload_in   = {first_beat, beat_last, s_axis.tdata};
  assign m_axis.tuser = payload_out[PAYLOAD_W-1];
`else
  assign payload_in   = {beat_last, s_axis.tdata};
`endif

  axis_skid_buf #(
    .C_WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (payload_in),
    .in_valid  (s_axis.tvalid),
    .in_ready  (s_ready),
    .out_data  (payload_out),
    .out_valid (m_axis.tvalid),
    .out_ready (m_axis.tready)
  );

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = payload_out[C_DATA_WIDTH-1:0];
  assign m_axis.tlast  = payload_out[C_DATA_WIDTH];
  assign beat_count    = beat_count_reg;
  assign pkt_count     = pkt_count_reg;

endmodule

// File: tb/tb_axis_tlast_framer.sv
// Self-checking bench for axis_tlast_framer: random data and backpressure,
// expected packet boundaries computed from packet-length arithmetic.
`timescale 1ns/1ps
module tb_axis_tlast_framer;
  import axis_tlast_framer_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [CW-1:0] cfg_len = '0;
  logic          flush = 1'b0;
  logic [CW-1:0] beat_count;
  logic [PW-1:0] pkt_count;

  axis_tlast_framer_if #(.DATA_WIDTH(DW)) s_if ();
  axis_tlast_framer_if #(.DATA_WIDTH(DW)) m_if ();

  axis_tlast_framer #(
    .C_DATA_WIDTH(DW), .C_COUNTER_WIDTH(CW), .C_NUMBER(16), .C_PKT_CNT_WIDTH(PW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .s_axis(s_if), .m_axis(m_if),
    .cfg_len(cfg_len), .flush(flush), .beat_count(beat_count), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] out_d[$];
  logic          out_l[$];
  logic          out_u[$];
  logic          exp_l[$];
  int            stall_viol;
  int            in_cycles;
  bit            timed_out;
  longint        exp_pkt = 0;

  // Drives n random beats, optional flush/cfg change at an input index,
  // records every output beat and any change of a stalled output.
  task automatic run(input int n, input int rdy_pct, input int flush_at,
                     input int chg_at, input logic [CW-1:0] len_new, input int max_cycles);
    int acc = 0;
    int cyc = 0;
    bit fl_done = 0;
    bit prev_stall = 0;
    logic [DW:0] prev_pl = '0;
    logic [DW-1:0] cur = $urandom;
    in_q.delete(); out_d.delete(); out_l.delete(); out_u.delete();
    stall_viol = 0; in_cycles = 0; timed_out = 0;
    while ((acc < n || out_d.size() < n) && cyc < max_cycles) begin
      s_if.tvalid = (acc < n);
      s_if.tdata  = cur;
      m_if.tready = ($urandom_range(99) < rdy_pct);
      flush = (flush_at >= 0) && !fl_done && (acc == flush_at) && (acc < n);
      fl_done = fl_done | flush;
      if (acc == chg_at) cfg_len = len_new;
      if (prev_stall && (!m_if.tvalid || {m_if.tlast, m_if.tdata} != prev_pl)) stall_viol++;
      if (m_if.tvalid && m_if.tready) begin
        out_d.push_back(m_if.tdata);
        out_l.push_back(m_if.tlast);
`ifdef TLAST_FRAMER_SOF_EN
        out_u.push_back(m_if.tuser);
`endif
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_pl = {m_if.tlast, m_if.tdata};
      if (s_if.tvalid && s_if.tready) begin
        in_q.push_back(cur);
        acc++;
        cur = $urandom;
        if (acc == n) in_cycles = cyc + 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    timed_out = (cyc >= max_cycles);
    s_if.tvalid = 1'b0;
    flush = 1'b0;
    m_if.tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (m_if.tvalid) begin
        out_d.push_back(m_if.tdata);
        out_l.push_back(m_if.tlast);
`ifdef TLAST_FRAMER_SOF_EN
        out_u.push_back(m_if.tuser);
`endif
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_if.tvalid); end
    checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b exp=0", m_if.tlast); end
    checks++; if (m_if.tdata !== '0) begin errors++; $display("FAIL reset_tdata got=%h exp=0", m_if.tdata); end
    checks++; if (beat_count !== '0 || pkt_count !== '0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", beat_count, pkt_count); end
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL reset_tready got=%b exp=0", s_if.tready); end
    reset_n = 1'b1;
    #1;
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL release_tready got=%b exp=0", s_if.tready); end
    @(posedge clk); #1;
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL first_edge_tready got=%b exp=1", s_if.tready); end
    $display("test_reset done");
  endtask

  task automatic test_len4();
    cfg_len = 4;
    run(12, 100, -1, -1, '0, 200);
    exp_l.delete();
    for (int i = 0; i < 12; i++) exp_l.push_back((i % 4) == 3);
    exp_pkt += 3;
    checks++; if (timed_out || out_d.size() != 12) begin errors++; $display("FAIL len4_count got=%0d exp=12", out_d.size()); end
    for (int i = 0; i < out_d.size() && i < 12; i++) begin
      checks++; if (out_d[i] !== in_q[i] || out_l[i] !== exp_l[i]) begin errors++; $display("FAIL len4_beat%0d got=%h/%b exp=%h/%b", i, out_d[i], out_l[i], in_q[i], exp_l[i]); end
    end
    checks++; if (in_cycles != 12) begin errors++; $display("FAIL len4_throughput got=%0d exp=12 cycles", in_cycles); end
    checks++; if (pkt_count !== PW'(exp_pkt) || beat_count !== '0) begin errors++; $display("FAIL len4_counts got=%0d/%0d exp=%0d/0", pkt_count, beat_count, exp_pkt); end
    $display("test_len4 done: %0d beats", out_d.size());
  endtask

  task automatic test_default_and_len1();
    cfg_len = 0;
    run(32, 100, -1, -1, '0, 300);
    checks++; if (timed_out || out_d.size() != 32) begin errors++; $display("FAIL deflen_count got=%0d exp=32", out_d.size()); end
    for (int i = 0; i < out_d.size() && i < 32; i++) begin
      checks++; if (out_d[i] !== in_q[i] || out_l[i] !== ((i % 16) == 15)) begin errors++; $display("FAIL deflen_beat%0d got=%h/%b exp=%h/%b", i, out_d[i], out_l[i], in_q[i], (i % 16) == 15); end
    end
    exp_pkt += 2;
    cfg_len = 1;
    run(5, 100, -1, -1, '0, 100);
    checks++; if (timed_out || out_d.size() != 5) begin errors++; $display("FAIL len1_count got=%0d exp=5", out_d.size()); end
    for (int i = 0; i < out_d.size() && i < 5; i++) begin
      checks++; if (out_l[i] !== 1'b1) begin errors++; $display("FAIL len1_beat%0d tlast got=%b exp=1", i, out_l[i]); end
    end
    exp_pkt += 5;
    checks++; if (pkt_count !== PW'(exp_pkt)) begin errors++; $display("FAIL len1_pkt got=%0d exp=%0d", pkt_count, exp_pkt); end
    $display("test_default_and_len1 done");
  endtask

  task automatic test_len_change();
    cfg_len = 8;
    run(14, 100, -1, 2, 16'd3, 200);
    checks++; if (timed_out || out_d.size() != 14) begin errors++; $display("FAIL lenchg_count got=%0d exp=14", out_d.size()); end
    for (int i = 0; i < out_d.size() && i < 14; i++) begin
      checks++; if (out_l[i] !== (i == 7 || i == 10 || i == 13)) begin errors++; $display("FAIL lenchg_beat%0d tlast got=%b exp=%b", i, out_l[i], (i == 7 || i == 10 || i == 13)); end
    end
    exp_pkt += 3;
    checks++; if (pkt_count !== PW'(exp_pkt)) begin errors++; $display("FAIL lenchg_pkt got=%0d exp=%0d", pkt_count, exp_pkt); end
    $display("test_len_change done");
  endtask

  task automatic test_flush();
    cfg_len = 8;
    run(11, 100, 2, -1, '0, 200);
    checks++; if (timed_out || out_d.size() != 11) begin errors++; $display("FAIL flush_count got=%0d exp=11", out_d.size()); end
    for (int i = 0; i < out_d.size() && i < 11; i++) begin
      checks++; if (out_l[i] !== (i == 2 || i == 10)) begin errors++; $display("FAIL flush_beat%0d tlast got=%b exp=%b", i, out_l[i], (i == 2 || i == 10)); end
    end
    exp_pkt += 2;
    checks++; if (beat_count !== '0 || pkt_count !== PW'(exp_pkt)) begin errors++; $display("FAIL flush_counts got=%0d/%0d exp=0/%0d", beat_count, pkt_count, exp_pkt); end
    // flush while idle at a packet boundary
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    repeat (2) @(posedge clk); #1;
    run(1, 100, -1, -1, '0, 50);
    exp_pkt += 1;
    checks++; if (out_l.size() != 1 || out_l[0] !== 1'b1) begin errors++; $display("FAIL idleflush_tlast got=%0d beats exp=1 beat with tlast", out_l.size()); end
    checks++; if (pkt_count !== PW'(exp_pkt) || beat_count !== '0) begin errors++; $display("FAIL idleflush_counts got=%0d/%0d exp=%0d/0", pkt_count, beat_count, exp_pkt); end
    // flush while idle mid-packet: pending flag terminates on the next beat
    run(3, 100, -1, -1, '0, 50);
    checks++; if (beat_count !== 16'd3) begin errors++; $display("FAIL midflush_pre got=%0d exp=3", beat_count); end
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    run(1, 100, -1, -1, '0, 50);
    exp_pkt += 1;
    checks++; if (out_l.size() != 1 || out_l[0] !== 1'b1) begin errors++; $display("FAIL midflush_tlast got=%0d beats exp=1 beat with tlast", out_l.size()); end
    checks++; if (pkt_count !== PW'(exp_pkt) || beat_count !== '0) begin errors++; $display("FAIL midflush_counts got=%0d/%0d exp=%0d/0", pkt_count, beat_count, exp_pkt); end
    $display("test_flush done");
  endtask

  task automatic test_backpressure();
    int bad = 0;
    cfg_len = 5;
    run(1000, 50, -1, -1, '0, 20000);
    checks++; if (timed_out || out_d.size() != 1000) begin errors++; $display("FAIL bp_count got=%0d exp=1000", out_d.size()); end
    for (int i = 0; i < out_d.size() && i < 1000; i++) begin
      if (out_d[i] !== in_q[i] || out_l[i] !== ((i % 5) == 4)) bad++;
`ifdef TLAST_FRAMER_SOF_EN
      if (out_u[i] !== ((i % 5) == 0)) bad++;
`endif
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_order got=%0d bad beats exp=0", bad); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got=%0d changes exp=0", stall_viol); end
    exp_pkt += 200;
    checks++; if (pkt_count !== PW'(exp_pkt)) begin errors++; $display("FAIL bp_pkt got=%0d exp=%0d", pkt_count, exp_pkt); end
    $display("test_backpressure done: %0d beats", out_d.size());
  endtask

  task automatic test_reset_mid_packet();
    cfg_len = 4;
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata = $urandom;
    repeat (4) @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    checks++; if (beat_count !== 16'd2 || m_if.tvalid !== 1'b1) begin errors++; $display("FAIL rst_pre got=%0d/%b exp=2/1", beat_count, m_if.tvalid); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0 || m_if.tlast !== 1'b0 || m_if.tdata !== '0) begin errors++; $display("FAIL rst_async got=%b/%b/%b/%h exp=0/0/0/0", m_if.tvalid, s_if.tready, m_if.tlast, m_if.tdata); end
    checks++; if (beat_count !== '0 || pkt_count !== '0) begin errors++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", beat_count, pkt_count); end
    @(posedge clk);
    #3 reset_n = 1'b1;
    exp_pkt = 0;
    run(4, 100, -1, -1, '0, 100);
    checks++; if (timed_out || out_d.size() != 4) begin errors++; $display("FAIL rst_post_count got=%0d exp=4", out_d.size()); end
    for (int i = 0; i < out_d.size() && i < 4; i++) begin
      checks++; if (out_d[i] !== in_q[i] || out_l[i] !== (i == 3)) begin errors++; $display("FAIL rst_post_beat%0d got=%h/%b exp=%h/%b", i, out_d[i], out_l[i], in_q[i], i == 3); end
    end
    exp_pkt += 1;
    checks++; if (pkt_count !== PW'(exp_pkt)) begin errors++; $display("FAIL rst_post_pkt got=%0d exp=%0d", pkt_count, exp_pkt); end
    $display("test_reset_mid_packet done");
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
`ifdef TLAST_FRAMER_SOF_EN
    s_if.tuser  = 1'b0;
`endif
    m_if.tready = 1'b1;
    test_reset();
    test_len4();
    test_default_and_len1();
    test_len_change();
    test_flush();
    test_backpressure();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
